// File: rtl/sillyfunction_checker.sv
// Response checker for sillyfunction: golden compare, vector/error counts, first-error capture, input coverage.
// Results are registered (visible the cycle after an accept); in_ready is high only in RUN. SILLY_CHK_STOP_ON_ERR_EN ends a run on the first mismatch.
module sillyfunction_checker #(
  parameter int CNT_W   = 8,
  parameter int NUM_VEC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       first_err_vec,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             err_seen,
  output logic [7:0]       coverage,
  output logic             done,
  output logic             pass
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0] state;
  logic [2:0] vec_idx;
  logic       y_exp;
  logic       accept;
  logic       mismatch;
  logic       last_vec;
  logic       end_run;

  assign vec_idx  = {a, b, c};
  assign y_exp    = (~b & ~c) | (a & ~b);
  assign in_ready = (state == ST_RUN);
  assign accept   = in_valid & in_ready;
  assign mismatch = accept & (y != y_exp);
  assign last_vec = (vec_count == LAST_IDX);

`ifdef SILLY_CHK_STOP_ON_ERR_EN
  assign end_run = accept & (last_vec | mismatch);
`else
  assign end_run = accept & last_vec;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_vec <= '0;
      first_err_idx <= '0;
      err_seen      <= 1'b0;
      coverage      <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A new run discards the previous run's results on the same edge.
          if (start) begin
            state         <= ST_RUN;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_vec <= '0;
            first_err_idx <= '0;
            err_seen      <= 1'b0;
            coverage      <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            vec_count         <= vec_count + ONE;
            coverage[vec_idx] <= 1'b1;
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + ONE;
              if (!err_seen) begin
                first_err_vec <= vec_idx;
                first_err_idx <= vec_count;
                err_seen      <= 1'b1;
              end
            end
            if (end_run) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= ~(err_seen | mismatch);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sillyfunction_checker.sv
// Randomised bench for sillyfunction_checker against a truth-table reference model.
module tb_sillyfunction_checker;

  localparam int CNT_W   = 8;
  localparam int NUM_VEC = 8;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_ready;
  logic             a, b, c, y;
  logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
  logic [2:0]       first_err_vec;
  logic             err_seen, done, pass;
  logic [7:0]       coverage;

  sillyfunction_checker #(.CNT_W(CNT_W), .NUM_VEC(NUM_VEC)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .y(y),
    .vec_count(vec_count), .err_count(err_count), .first_err_vec(first_err_vec),
    .first_err_idx(first_err_idx), .err_seen(err_seen), .coverage(coverage),
    .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Golden table indexed by {a,b,c}: 000,100,101 give 1.
  logic [7:0] tt = 8'b0011_0001;

  logic [2:0] sv[$];
  logic       sy[$];
  bit         gap_en;

  int         m_cnt, m_err, m_first_idx;
  logic [2:0] m_first_vec;
  logic [7:0] m_cov;
  bit         m_seen, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clean(input logic [2:0] v);
    sv.push_back(v);
    sy.push_back(tt[v]);
  endtask

  task automatic push_bad(input logic [2:0] v);
    sv.push_back(v);
    sy.push_back(~tt[v]);
  endtask

  task automatic push_all_clean();
    for (int i = 0; i < 8; i++) push_clean(3'(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_count"}, 32'(vec_count), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_first_vec"}, 32'(first_err_vec), 0);
    check({tag, "_first_idx"}, 32'(first_err_idx), 0);
    check({tag, "_err_seen"}, 32'(err_seen), 0);
    check({tag, "_coverage"}, 32'(coverage), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Drives the queued vectors and compares against the model after every accept and at the end.
  task automatic run_seq(input string tag);
    bit bad;
    m_cnt = 0; m_err = 0; m_first_idx = 0; m_first_vec = '0;
    m_cov = '0; m_seen = 0; m_done = 0;
    for (int i = 0; i < sv.size(); i++) begin
      if (m_done) break;
      if (gap_en) begin
        repeat ($urandom_range(0, 2)) begin
          start = 1'($urandom_range(0, 1));
          {a, b, c} = 3'($urandom_range(0, 7));
          tick();
          start = 1'b0;
        end
      end
      check({tag, "_in_ready"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      {a, b, c} = sv[i];
      y = sy[i];
      tick();
      in_valid = 1'b0;
      bad = (sy[i] != tt[sv[i]]);
      if (bad) begin
        if (!m_seen) begin
          m_seen = 1;
          m_first_vec = sv[i];
          m_first_idx = m_cnt;
        end
        if (m_err < 255) m_err++;
      end
      m_cov[sv[i]] = 1'b1;
      m_cnt++;
      if (m_cnt == NUM_VEC) m_done = 1;
`ifdef SILLY_CHK_STOP_ON_ERR_EN
      if (bad) m_done = 1;
`endif
      check({tag, "_step_vec_count"}, 32'(vec_count), 32'(m_cnt));
    end
    check({tag, "_vec_count"}, 32'(vec_count), 32'(m_cnt));
    check({tag, "_err_count"}, 32'(err_count), 32'(m_err));
    check({tag, "_first_vec"}, 32'(first_err_vec), 32'(m_first_vec));
    check({tag, "_first_idx"}, 32'(first_err_idx), 32'(m_first_idx));
    check({tag, "_err_seen"}, 32'(err_seen), 32'(m_seen));
    check({tag, "_coverage"}, 32'(coverage), 32'(m_cov));
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_pass"}, 32'(pass), 32'(m_done && !m_seen));
    check({tag, "_in_ready_end"}, 32'(in_ready), 32'(!m_done));
    sv.delete();
    sy.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; y = 1'b0; gap_en = 0;
    repeat (2) tick();
    reset = 1'b0;
    check_all_zero("reset");
    check("reset_pass", 32'(pass), 0);
    check("reset_in_ready", 32'(in_ready), 0);

    // in_valid while idle is ignored.
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    check("idle_vec_count", 32'(vec_count), 0);
    check("idle_in_ready", 32'(in_ready), 0);

    pulse_start();
    check("start_in_ready", 32'(in_ready), 1);
    push_all_clean();
    run_seq("clean");
    check("clean_coverage_full", 32'(coverage), 32'hFF);

    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 5) push_bad(3'(i));
      else push_clean(3'(i));
    end
    run_seq("two_err");
    check("two_err_first_vec", 32'(first_err_vec), 32'b011);

    // Restart from DONE wins over a coincident vector.
    start = 1'b1; in_valid = 1'b1; {a, b, c} = 3'b000; y = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check_all_zero("restart");
    check("restart_in_ready", 32'(in_ready), 1);
    push_all_clean();
    run_seq("after_restart");

    pulse_start();
    gap_en = 1;
    push_clean(3'b001); push_clean(3'b001); push_clean(3'b001); push_clean(3'b100);
    push_clean(3'b110); push_clean(3'b000); push_clean(3'b010); push_clean(3'b011);
    run_seq("cov_list");
    check("cov_list_pattern", 32'(coverage), 32'h5F);

    // Reset mid-run discards partial results.
    pulse_start();
    push_clean(3'b000); push_bad(3'b101); push_clean(3'b110); push_clean(3'b111);
    run_seq("partial");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    check("midreset_in_ready", 32'(in_ready), 0);
    pulse_start();
    push_all_clean();
    run_seq("post_reset");

    for (int r = 0; r < 6; r++) begin
      pulse_start();
      for (int i = 0; i < NUM_VEC; i++) begin
        logic [2:0] v;
        v = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 5) == 0) push_bad(v);
        else push_clean(v);
      end
      run_seq("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sillyfunction_checker.md
Name: sillyfunction_checker

Overview:
- Response-side checker for the sillyfunction combinational block. It consumes applied {a,b,c} vectors together with the observed y, recomputes the golden y = (~b & ~c) | (a & ~b), and counts vectors and mismatches.
- It also records the first failing vector and tracks coverage of all 8 input combinations.
- It sits beside the DUT in a hardware self-test wrapper, the opposite end from the vector driver, and reports a pass/fail verdict.

Parameters:
- CNT_W, 8, width of the vector and error counters.
- NUM_VEC, 8, number of accepted vectors after which the run completes. Legal range is 1 to 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE
- in_valid  input  1  vector {a,b,c,y} present this cycle
- in_ready  output  1  checker accepts a vector this cycle
- a  input  1  applied DUT input a
- b  input  1  applied DUT input b
- c  input  1  applied DUT input c
- y  input  1  observed DUT output
- vec_count  output  CNT_W  vectors accepted in the current run
- err_count  output  CNT_W  mismatches in the current run; saturates at all-ones
- first_err_vec  output  3  {a,b,c} of the first mismatch; 0 if none
- first_err_idx  output  CNT_W  value of vec_count at the first mismatch
- err_seen  output  1  at least one mismatch this run
- coverage  output  8  bit {a,b,c} is set once that combination has been accepted
- done  output  1  run complete
- pass  output  1  done and err_count==0

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; all counters, first_err_vec, first_err_idx and coverage are 0; err_seen, done, pass and in_ready are 0.
- FSM states:
  - IDLE: start leads to RUN.
  - RUN: moves to DONE on the accept that makes vec_count==NUM_VEC.
  - DONE: start leads to RUN.
- Entering RUN from IDLE or DONE clears vec_count, err_count, first_err_*, err_seen, coverage, done and pass on the same edge.
- in_ready = (state==RUN). It is combinational from state only and never depends on in_valid.
- Accept condition: in_valid & in_ready on a rising edge. On an accept:
  - vec_count increments.
  - coverage[{a,b,c}] is set.
  - If y != y_exp: err_count increments (saturating). If err_seen==0, first_err_vec<={a,b,c}, first_err_idx<=vec_count (pre-increment value), and err_seen<=1.
- Latency: all outputs are registered and reflect an accept on the edge that accepts it (visible the following cycle).
- done is asserted in the cycle after the final accept. pass = done & ~err_seen.
- in_valid while in IDLE or DONE is ignored; there is no state change and no count.
- start while in RUN is ignored; the run continues.
- start together with in_valid in the DONE cycle: the restart wins and the vector is not accepted, because in_ready is 0 in that cycle.
- vec_count never exceeds NUM_VEC. The run ends exactly at NUM_VEC, so vec_count does not wrap.
- Reset asserted mid-run: all state returns to reset values on the next edge and any partial results are discarded.
- Golden truth table for y_exp, with index {a,b,c}:
  - 000→1, 001→0, 010→0, 011→0
  - 100→1, 101→1, 110→0, 111→0

Optional Feature:
- Macro: SILLY_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatching accept moves RUN to DONE on that same edge. vec_count includes the failing vector, done=1 and pass=0 in the next cycle.
- Not defined: mismatches never end the run early; the run always completes after NUM_VEC accepts.

Test Plan:
1. reset, then start. Apply the 8 vectors 000..111, each with correct y and in_valid=1 every cycle. Expected: vec_count=8, err_count=0, coverage=8'hFF, done=1 and pass=1 one cycle after the 8th accept; in_ready=0 after that.
2. Same sequence, but drive y=1 for 011 (index 3) and y=0 for 101 (index 5). Expected: err_count=2, first_err_vec=3'b011, first_err_idx=3, err_seen=1, pass=0. With SILLY_CHK_STOP_ON_ERR_EN defined: done=1 after the 4th accept, vec_count=4, err_count=1.
3. Hold in_valid=1 while in IDLE for 5 cycles, then start and give 3 idle gaps (in_valid=0) between vectors. Expected: no counting before start, gaps not counted, vec_count reaches 8 only after 8 real accepts.
4. Apply vectors 001,001,001,100,110,000,010,011. Expected: coverage=8'b0101_1111 (bits 0,1,2,3,4,6 set), err_count=0, pass=1.
5. Assert reset after 4 accepts with one mismatch recorded. Expected: next cycle all outputs 0 and state IDLE. A new start plus 8 clean vectors then gives pass=1.
6. In DONE with pass=0, pulse start together with in_valid=1. Expected: that vector is not accepted, counters and err_seen clear, done=0. The following 8 clean vectors give pass=1.
